// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input; the reset value is
// chosen per use so that leaving reset presents the input's idle level.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit glitch filter, mid-bit sampling, framing-error
// detection, and a BREAK state that swallows a line held low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_BAUD = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_baud,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_PER_BAUD);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BAUD - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLK_PER_BAUD / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  if (CLK_PER_BAUD < 4 || (CLK_PER_BAUD % 2) != 0) begin : g_bad_cpb
    $error("uart_rx: CLK_PER_BAUD must be even and at least 4");
  end

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx: SYNC_STAGES must be at least 2");
  end

  rx_state_t            state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxs;

  // Reset to 1 so a line that idles high never looks like a start edge.
  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk_baud),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end

        // A start bit that is gone again by mid-bit was a glitch.
        START: begin
          if (baud_cnt == BAUD_HALF) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rxs ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rxs, shreg[DATA_BITS-1:1]};
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        // Leaving at mid stop bit gives half a bit of slack for the next start.
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (rxs) begin
              rx_byte <= shreg;
              valid   <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a bit-level serial driver plays the transmitter, and a
// scoreboard queue holds the bytes that must come out with a valid pulse.
module tb_uart_rx;

  localparam int CPB = 4;
  localparam int SS  = 2;

  logic       clk_baud = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_PER_BAUD(CPB),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_baud (clk_baud),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk_baud = ~clk_baud;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_busy_hi = 0;
  int low_run = 0;
  int last_gap = 0;
  int last_start = 0;
  logic [7:0] exp_q[$];
  int vcyc_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_baud);
      cyc++;
    end
  end

  // Output monitor: scoreboard pops, pulse counters, idle-gap tracking.
  initial begin
    forever begin
      @(negedge clk_baud);
      if (valid) begin
        n_valid++;
        vcyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_valid: got byte 0x%0h, expected no valid", rx_byte);
        end else begin
          check("rx_byte", int'(rx_byte), int'(exp_q.pop_front()));
        end
      end
      if (frame_err) n_ferr++;
      if (valid && frame_err) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pulse_exclusive: got valid=1 frame_err=1, expected at most one");
      end
      if (busy) begin
        n_busy_hi++;
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_baud);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk_baud);
  endtask

  // Leaves rx at the stop-bit level so a low stop can be held as a break.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    last_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    int v0, f0, h0, k;

    vecs[0] = '{8'h00, 1'b1, 6, 1, 0};
    vecs[1] = '{8'hFF, 1'b1, 7, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 6, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 9, 1, 0};
    vecs[4] = '{8'h81, 1'b0, 8, 0, 1};
    vecs[5] = '{8'hC3, 1'b1, 6, 1, 0};
    vecs[6] = '{8'h5A, 1'b1, 7, 1, 0};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk_baud);
    check("reset_rx_byte", int'(rx_byte), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(5);
    check("idle_after_reset_busy", int'(busy), 0);

    // Single "0" frame plus latency from first low sample to valid.
    v0 = n_valid; f0 = n_ferr;
    vcyc_q.delete();
    exp_q.push_back(8'h30);
    send_frame(8'h30, 1'b1);
    idle(6);
    check("ascii0_valid_count", n_valid - v0, 1);
    check("ascii0_frame_err_count", n_ferr - f0, 0);
    check("ascii0_rx_byte_held", int'(rx_byte), 8'h30);
    if (vcyc_q.size() == 1) check("latency", vcyc_q[0] - (last_start + 1), SS + CPB/2 + 9*CPB);
    else check("latency_pulses", vcyc_q.size(), 1);

    for (int i = 0; i < 7; i++) begin
      v0 = n_valid; f0 = n_ferr;
      if (vecs[i].exp_valid != 0) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle(vecs[i].gap);
      check($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_busy", i), int'(busy), 0);
    end
    check("after_bad_stop_rx_byte", int'(rx_byte), 8'hC3 ^ 8'hC3 ^ 8'h5A);

    // Back-to-back frames with no idle time.
    vcyc_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle(8);
    check("b2b_pulses", vcyc_q.size(), 2);
    if (vcyc_q.size() == 2) check("b2b_spacing", vcyc_q[1] - vcyc_q[0], 10*CPB);
    check("b2b_idle_gap", last_gap, SS);

    // One-cycle low glitch.
    v0 = n_valid; f0 = n_ferr; h0 = n_busy_hi;
    rx = 1'b0;
    k = cyc;
    @(negedge clk_baud);
    rx = 1'b1;
    while (cyc < k + 1 + SS + CPB/2 + 1) @(negedge clk_baud);
    check("glitch_back_idle", int'(busy), 0);
    idle(10);
    check("glitch_busy_cycles", n_busy_hi - h0, CPB/2);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    // Good 3C, then 00 with a low stop bit held low as a break.
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle(4);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h00, 1'b0);
    repeat (12) @(negedge clk_baud);
    check("break_busy_held", int'(busy), 1);
    check("break_ferr", n_ferr - f0, 1);
    check("break_no_valid", n_valid - v0, 0);
    check("break_rx_byte", int'(rx_byte), 8'h3C);
    repeat (20) @(negedge clk_baud);
    check("break_single_ferr", n_ferr - f0, 1);
    idle(5);
    check("break_released", int'(busy), 0);

    // Reset after the third data bit of FF, then a clean A5.
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("pre_abort_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk_baud);
    check("abort_rx_byte", int'(rx_byte), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
    check("abort_frame_err", int'(frame_err), 0);
    @(negedge clk_baud);
    rst = 1'b0;
    idle(50);
    check("abort_no_valid", n_valid - v0, 0);
    check("abort_no_ferr", n_ferr - f0, 0);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(6);
    check("after_abort_valid", n_valid - v0, 1);
    check("after_abort_rx_byte", int'(rx_byte), 8'hA5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
